// File: rtl/lms_mu_scheduler.sv
// Step-size scheduler for the LMS adaptive FIR: leaky-averages |error| and walks
// mu_out from a fast acquisition shift to a slow tracking shift, falling back on loss of lock.
module lms_mu_scheduler #(
  parameter int EW      = 33,
  parameter int AVG_SH  = 6,
  parameter int MU_FAST = 4,
  parameter int MU_SLOW = 10,
  parameter int SETTLE  = 64,
  parameter int STEP    = 16,
  parameter int LOSS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [EW-1:0] e_in,
  input  logic                 en,
  input  logic        [EW-1:0] thresh_in,
  output logic        [7:0]    mu_out,
  output logic        [EW-1:0] pwr_out,
  output logic                 locked,
  output logic                 relock_pulse,
  output logic        [1:0]    state_out
);

  localparam int AW  = EW + AVG_SH;
  localparam int SCW = $clog2(SETTLE + 1);
  localparam int PCW = $clog2(STEP + 1);
  localparam int LCW = $clog2(LOSS + 1);

  localparam logic [SCW-1:0] SETTLE_C = SCW'(SETTLE);
  localparam logic [PCW-1:0] STEP_C   = PCW'(STEP);
  localparam logic [LCW-1:0] LOSS_C   = LCW'(LOSS);
  localparam logic [7:0]     MU_F     = 8'(MU_FAST);
  localparam logic [7:0]     MU_S     = 8'(MU_SLOW);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    RAMP  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       mu_q, mu_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [SCW-1:0]   settle_q, settle_d, settle_inc;
  logic [PCW-1:0]   step_q, step_d, step_inc;
  logic [LCW-1:0]   loss_q, loss_d, loss_inc;
  logic             locked_q, locked_d;
  logic             relock_q, relock_d;
  logic [EW-1:0]    mag;
  logic [EW-1:0]    pwr;
  logic             pwr_low;
  logic             pwr_high;

  // Two's-complement negate of the most-negative value yields 2^(EW-1) read as unsigned.
  assign mag      = e_in[EW-1] ? $unsigned(-e_in) : $unsigned(e_in);
  assign pwr      = acc_q[AW-1:AVG_SH];
  assign pwr_low  = pwr < thresh_in;
  assign pwr_high = {2'b00, pwr} >= {thresh_in, 2'b00};

  assign settle_inc = (settle_q == '1) ? settle_q : settle_q + 1'b1;
  assign step_inc   = (step_q == '1) ? step_q : step_q + 1'b1;
  assign loss_inc   = (loss_q == '1) ? loss_q : loss_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    mu_d     = mu_q;
    acc_d    = acc_q;
    settle_d = settle_q;
    step_d   = step_q;
    loss_d   = loss_q;
    relock_d = 1'b0;

    if (en) begin
      // Subtract the leak first so the intermediate never exceeds the accumulator width.
      acc_d = acc_q - (acc_q >> AVG_SH) + AW'(mag);

      unique case (state_q)
        ACQ: begin
          mu_d = MU_F;
          if (pwr_low) begin
            if (settle_inc == SETTLE_C) begin
              state_d  = RAMP;
              settle_d = '0;
              step_d   = '0;
            end else begin
              settle_d = settle_inc;
            end
          end else begin
            settle_d = '0;
          end
        end

        RAMP: begin
          if (pwr_high) begin
            state_d  = ACQ;
            mu_d     = MU_F;
            settle_d = '0;
            step_d   = '0;
            loss_d   = '0;
          end else if (step_inc == STEP_C) begin
            mu_d   = mu_q + 8'd1;
            step_d = '0;
            if (mu_q + 8'd1 == MU_S) begin
              state_d = TRACK;
              loss_d  = '0;
            end
          end else begin
            step_d = step_inc;
          end
        end

        TRACK: begin
          mu_d = MU_S;
          if (pwr_high) begin
            if (loss_inc == LOSS_C) begin
              state_d  = ACQ;
              mu_d     = MU_F;
              relock_d = 1'b1;
              loss_d   = '0;
              settle_d = '0;
              step_d   = '0;
            end else begin
              loss_d = loss_inc;
            end
          end else begin
            loss_d = '0;
          end
        end

        default: begin
          state_d = ACQ;
          mu_d    = MU_F;
        end
      endcase
    end

    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACQ;
      mu_q     <= MU_F;
      acc_q    <= '0;
      settle_q <= '0;
      step_q   <= '0;
      loss_q   <= '0;
      locked_q <= 1'b0;
      relock_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mu_q     <= mu_d;
      acc_q    <= acc_d;
      settle_q <= settle_d;
      step_q   <= step_d;
      loss_q   <= loss_d;
      locked_q <= locked_d;
      relock_q <= relock_d;
    end
  end

  assign mu_out       = mu_q;
  assign pwr_out      = pwr;
  assign locked       = locked_q;
  assign relock_pulse = relock_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_lms_mu_scheduler.sv
// Directed bench for lms_mu_scheduler: vector table for reset/averaging, then
// hand sequences for lock, loss of lock, extremes, freeze and RAMP abort.
module tb_lms_mu_scheduler;

  logic               clk;
  logic               reset;
  logic signed [32:0] e_in;
  logic               en;
  logic [32:0]        thresh_in;
  logic [7:0]         mu_out;
  logic [32:0]        pwr_out;
  logic               locked;
  logic               relock_pulse;
  logic [1:0]         state_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic               rst;
    logic               en;
    logic signed [32:0] e;
    logic [32:0]        th;
    logic [7:0]         mu;
    logic [32:0]        pwr;
    logic [1:0]         st;
    logic               lk;
    logic               rl;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  logic signed [32:0] neg_max;
  longint             prev_pwr;
  longint             acc_m;
  longint             pre_pwr;
  int                 mono_ok;
  int                 reached;
  int                 in_track;
  int                 run_cnt;
  int                 pulse_exp;
  int                 pulses_seen;
  int                 exp_mu;
  int                 exp_st;
  int                 exp_lk;
  int                 iter;

  lms_mu_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .e_in         (e_in),
    .en           (en),
    .thresh_in    (thresh_in),
    .mu_out       (mu_out),
    .pwr_out      (pwr_out),
    .locked       (locked),
    .relock_pulse (relock_pulse),
    .state_out    (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic r, input logic n, input logic signed [32:0] e,
                                 input logic [32:0] th, input logic [7:0] mu, input logic [32:0] pwr,
                                 input logic [1:0] st, input logic lk, input logic rl);
    vec_t v;
    v.rst = r; v.en = n; v.e = e; v.th = th; v.mu = mu;
    v.pwr = pwr; v.st = st; v.lk = lk; v.rl = rl;
    return v;
  endfunction

  // Drive inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic n, input logic signed [32:0] e,
                               input logic [32:0] th);
    reset     = r;
    en        = n;
    e_in      = e;
    thresh_in = th;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input int mu, input longint pwr, input int st,
                             input int lk, input int rl);
    checkValue({name, ".mu"}, longint'(mu_out), longint'(mu));
    checkValue({name, ".pwr"}, longint'(pwr_out), pwr);
    checkValue({name, ".state"}, longint'(state_out), longint'(st));
    checkValue({name, ".locked"}, longint'(locked), longint'(lk));
    checkValue({name, ".relock"}, longint'(relock_pulse), longint'(rl));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; e_in = '0; thresh_in = '0;
    neg_max = {1'b1, 32'd0};

    vecs[0]  = mkVec(1, 1, 5000,    256, 4, 0,        0, 0, 0);
    vecs[1]  = mkVec(1, 1, 5000,    256, 4, 0,        0, 0, 0);
    vecs[2]  = mkVec(0, 1, 0,       256, 4, 0,        0, 0, 0);
    vecs[3]  = mkVec(0, 1, 0,       256, 4, 0,        0, 0, 0);
    vecs[4]  = mkVec(0, 1, 0,       256, 4, 0,        0, 0, 0);
    vecs[5]  = mkVec(0, 1, 0,       256, 4, 0,        0, 0, 0);
    vecs[6]  = mkVec(1, 1, 0,       256, 4, 0,        0, 0, 0);
    vecs[7]  = mkVec(0, 1, 1000,    256, 4, 15,       0, 0, 0);
    vecs[8]  = mkVec(0, 1, 1000,    256, 4, 31,       0, 0, 0);
    vecs[9]  = mkVec(0, 0, 1000,    256, 4, 31,       0, 0, 0);
    vecs[10] = mkVec(0, 1, -1000,   256, 4, 46,       0, 0, 0);
    vecs[11] = mkVec(0, 1, 0,       256, 4, 45,       0, 0, 0);
    vecs[12] = mkVec(1, 1, 0,       256, 4, 0,        0, 0, 0);
    vecs[13] = mkVec(0, 1, neg_max, 256, 4, 67108864, 0, 0, 0);
    vecs[14] = mkVec(0, 1, 0,       256, 4, 66060288, 0, 0, 0);
    vecs[15] = mkVec(1, 0, 5000,    256, 4, 0,        0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].e, vecs[i].th);
      checkOutput($sformatf("vec%0d", i), int'(vecs[i].mu), longint'(vecs[i].pwr),
                  int'(vecs[i].st), int'(vecs[i].lk), int'(vecs[i].rl));
    end

    // Averaging converges monotonically to the input magnitude.
    applyStimulus(1, 1, 0, 0);
    prev_pwr = 0;
    mono_ok  = 1;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(0, 1, 1000, 0);
      if (longint'(pwr_out) < prev_pwr) mono_ok = 0;
      prev_pwr = longint'(pwr_out);
    end
    checkValue("avg_monotone", mono_ok, 1);
    checkValue("avg_converge", (pwr_out >= 33'd999 && pwr_out <= 33'd1001) ? 1 : 0, 1);
    checkValue("avg_state", longint'(state_out), 0);

    // Full lock sequence with zero error.
    applyStimulus(1, 1, 0, 256);
    for (int k = 1; k <= 165; k++) begin
      applyStimulus(0, 1, 0, 256);
      if (k < 64) begin
        exp_st = 0; exp_mu = 4; exp_lk = 0;
      end else if (k < 160) begin
        exp_st = 1; exp_mu = 4 + (k - 64) / 16; exp_lk = 0;
      end else begin
        exp_st = 2; exp_mu = 10; exp_lk = 1;
      end
      checkOutput($sformatf("lock_e%0d", k), exp_mu, 0, exp_st, exp_lk, 0);
    end

    // Loss of lock from TRACK with a sustained large error.
    acc_m       = 0;
    in_track    = 1;
    run_cnt     = 0;
    pulses_seen = 0;
    for (int k = 1; k <= 70; k++) begin
      pre_pwr   = acc_m >> 6;
      acc_m     = acc_m + 2000 - (acc_m >> 6);
      pulse_exp = 0;
      if (in_track == 1) begin
        if (pre_pwr >= 1024) run_cnt++;
        else run_cnt = 0;
        if (run_cnt == 8) begin
          in_track  = 0;
          pulse_exp = 1;
        end
      end
      applyStimulus(0, 1, -2000, 256);
      if (relock_pulse) pulses_seen++;
      checkOutput($sformatf("loss_e%0d", k), in_track ? 10 : 4, acc_m >> 6,
                  in_track ? 2 : 0, in_track, pulse_exp);
    end
    checkValue("loss_pulse_count", pulses_seen, 1);

    // Most-negative input and saturation-free growth toward 2^32.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, neg_max, 0);
    checkValue("ext_first_pwr", longint'(pwr_out), 64'd67108864);
    prev_pwr = longint'(pwr_out);
    mono_ok  = 1;
    reached  = 0;
    iter     = 0;
    while (reached == 0 && iter < 3000) begin
      applyStimulus(0, 1, neg_max, 0);
      if (longint'(pwr_out) < prev_pwr || longint'(pwr_out) > 64'd4294967296) mono_ok = 0;
      prev_pwr = longint'(pwr_out);
      if (longint'(pwr_out) > 64'd4294967168) reached = 1;
      iter++;
    end
    checkValue("ext_reached", reached, 1);
    checkValue("ext_no_wrap", mono_ok, 1);

    // Freeze in RAMP at mu=7, then mid-operation reset.
    applyStimulus(1, 1, 0, 256);
    for (int k = 1; k <= 115; k++) applyStimulus(0, 1, 0, 256);
    checkOutput("frz_pre", 7, 0, 1, 0, 0);
    for (int k = 0; k < 50; k++) begin
      applyStimulus(0, 0, 5000, 256);
      checkOutput($sformatf("frz_c%0d", k), 7, 0, 1, 0, 0);
    end
    applyStimulus(1, 1, 0, 256);
    checkOutput("mid_reset", 4, 0, 0, 0, 0);

    // RAMP abort on high error power: no relock pulse.
    for (int k = 1; k <= 90; k++) applyStimulus(0, 1, 0, 256);
    checkOutput("abort_pre", 5, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("abort", 4, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("abort_stay", 4, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
